// File: rtl/seq_timer_fsm.sv
// Start-pattern detector followed by a serial delay load and a unit-scaled countdown timer.
// done is held until acknowledged; abort returns to a fresh search from any state.
module seq_timer_fsm #(
  parameter         PATTERN         = 4'b1101,
  parameter int     PAT_LEN         = 4,
  parameter int     DELAY_W         = 4,
  parameter int     CYCLES_PER_UNIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  input  logic               abort,
  output logic               shift_ena,
  output logic               counting,
  output logic [DELAY_W-1:0] count,
  output logic               done
);

  // The oldest history bit and the oldest delay bit fall off before they are ever
  // compared or loaded, so both registers keep one bit less than the field width.
  localparam int HIST_W = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
  localparam int FILL_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int DLY_W  = (DELAY_W > 1) ? DELAY_W - 1 : 1;
  localparam int BIT_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
  localparam int CYC_W  = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;

  localparam logic [PAT_LEN-1:0] PAT      = PAT_LEN'(PATTERN);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DELAY_W - 1);
  localparam logic [CYC_W-1:0]   CYC_MAX  = CYC_W'(CYCLES_PER_UNIT - 1);

  typedef enum logic [1:0] {SEARCH, SHIFT, COUNT, DONE} state_t;

  state_t state, state_nxt;

  logic [HIST_W-1:0]  hist;
  logic [FILL_W-1:0]  fill;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DLY_W-1:0]   dly;
  logic [DELAY_W-1:0] units;
  logic [CYC_W-1:0]   cyc;

  logic [HIST_W:0] hist_cat;
  logic [DLY_W:0]  dly_cat;
  logic            match;
  logic            shift_last;
  logic            count_end;

  assign hist_cat   = {hist, data};
  assign dly_cat    = {dly, data};
  assign match      = (fill == FILL_MAX) && (hist_cat[PAT_LEN-1:0] == PAT);
  assign shift_last = (bit_cnt == BIT_LAST);
  assign count_end  = (cyc == '0) && (units == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_ena = 1'b0;
    counting  = 1'b0;
    count     = '0;
    done      = 1'b0;
    case (state)
      SEARCH: if (match) state_nxt = SHIFT;
      SHIFT: begin
        shift_ena = 1'b1;
        if (shift_last) state_nxt = COUNT;
      end
      COUNT: begin
        counting = 1'b1;
        count    = units;
        if (count_end) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (ack) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
    if (abort) state_nxt = SEARCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      fill    <= '0;
      bit_cnt <= '0;
      dly     <= '0;
      units   <= '0;
      cyc     <= '0;
    end else if (abort) begin
      hist    <= '0;
      fill    <= '0;
      bit_cnt <= '0;
      dly     <= '0;
      units   <= '0;
      cyc     <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (match) begin
            hist    <= '0;
            fill    <= '0;
            bit_cnt <= '0;
          end else begin
            hist <= hist_cat[HIST_W-1:0];
            if (fill != FILL_MAX) fill <= fill + FILL_W'(1);
          end
        end
        SHIFT: begin
          dly <= dly_cat[DLY_W-1:0];
          if (shift_last) begin
            // The final delay bit arrives on this edge, so load from the concatenation.
            bit_cnt <= '0;
            units   <= dly_cat[DELAY_W-1:0];
            cyc     <= CYC_MAX;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        COUNT: begin
          if (cyc != '0) begin
            cyc <= cyc - CYC_W'(1);
          end else if (units != '0) begin
            units <= units - DELAY_W'(1);
            cyc   <= CYC_MAX;
          end
        end
        DONE: begin
          if (ack) begin
            hist <= '0;
            fill <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_timer_fsm.md
# seq_timer_fsm

Parametrised start-sequence detector and programmable timer. Watches a serial `data` stream for a configurable start pattern, shifts in a DELAY_W-bit delay value MSB-first, then counts down (delay+1)·CYCLES_PER_UNIT cycles. While counting it reports the remaining units, then holds `done` until the user acknowledges. It is the generalised successor of the fixed 1101 / 4-bit complete-FSM controller: it adds a configurable pattern and widths, an internal shifter and counter, and a synchronous `abort`.

## Interface
- PATTERN, 4'b1101, start pattern; bit PAT_LEN-1 is received first.
- PAT_LEN, 4, pattern length in bits (≥1).
- DELAY_W, 4, delay field width in bits (≥1).
- CYCLES_PER_UNIT, 1000, clock cycles per delay unit (≥1).
- clk  input  1  rising-edge clock; the block has one clock only.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data  input  1  serial input, sampled every rising edge.
- ack  input  1  acknowledge; sampled only in DONE.
- abort  input  1  synchronous abort; returns the FSM to SEARCH.
- shift_ena  output  1  high while delay bits are being shifted in.
- counting  output  1  high while the timer runs.
- count  output  DELAY_W  remaining whole units while counting; 0 otherwise.
- done  output  1  high in DONE until acknowledged.

## Operation
- States: SEARCH, SHIFT, COUNT, DONE. All outputs are Moore outputs decoded from registered state and registers.
- SEARCH
  - Shift `data` into a PAT_LEN-bit history register, LSB = newest bit.
  - A saturating fill counter tracks bits received since entry.
  - Match when fill ≥ PAT_LEN-1 and {hist[PAT_LEN-2:0], data} == PATTERN. On a match, go to SHIFT.
  - Detection is overlapping: stream 1,1,1,0,1 matches 1101 on its 5th bit.
- SHIFT
  - shift_ena=1 for exactly DELAY_W cycles.
  - Each cycle: delay <= {delay[DELAY_W-2:0], data}.
  - A bit counter runs 0..DELAY_W-1. After the last bit, go to COUNT.
- COUNT
  - On entry: units=delay, cyc=CYCLES_PER_UNIT-1.
  - Each cycle: if cyc≠0 then cyc--; else if units≠0 then units--, cyc=CYCLES_PER_UNIT-1; else go to DONE.
  - counting=1 and count=units throughout.
  - Total cycles in COUNT = (delay+1)·CYCLES_PER_UNIT.
  - cyc width = max(1, $clog2(CYCLES_PER_UNIT)). All arithmetic is unsigned, with no wrap.
- DONE
  - done=1.
  - ack=1 → SEARCH, with history and fill cleared.
  - ack=0 → stay in DONE.
- abort=1 in any state → SEARCH on the next edge, clearing history, fill, bit counter, delay, units and cyc. abort takes priority over every transition, including match, last shift bit, terminal count and ack.
- `data` is ignored in COUNT and DONE. `ack` is ignored outside DONE.
- Reset (reset=0), asynchronous and effective immediately, including mid-shift or mid-count:
  - state=SEARCH and all registers = 0.
  - shift_ena=0, counting=0, count=0, done=0.
  - Leaving reset starts a fresh search; no partial pattern is retained.

## Timing
- Last pattern bit sampled at edge t → shift_ena high for cycles t..t+DELAY_W-1, i.e. the state is SHIFT after edges t … t+DELAY_W-1.
- First delay bit is sampled at edge t+1. The MSB of the delay is the first bit after the pattern.
- counting rises after edge t+DELAY_W and stays high for (delay+1)·CYCLES_PER_UNIT cycles.
- done rises on the cycle after the terminal count. There are no idle cycles between phases.
- count steps down once every CYCLES_PER_UNIT cycles: from delay down to 0.
- ack high during DONE → done=0 and SEARCH from the next cycle. Earliest new match is PAT_LEN cycles later.
- Minimum start-to-done latency: PAT_LEN + DELAY_W + (delay+1)·CYCLES_PER_UNIT cycles.

## Test plan
Unless a line says otherwise, the bench uses PATTERN=4'b1101, PAT_LEN=4, DELAY_W=4, CYCLES_PER_UNIT=4.
- **Basic run:** data 1,1,0,1 then 0,1,0,1 (delay=5) → shift_ena high 4 cycles. Then counting high 24 cycles with count 5,5,5,5,4,…,0. done rises next cycle and holds until ack=1, then SEARCH.
- **Overlap and false starts:** data 1,1,1,0,0,1,1,0,1 → exactly one match, on the 9th bit. Stream 1,1,0,0,1,1,0,1 matches on the 8th bit.
- **Zero delay:** delay bits 0,0,0,0 → counting exactly 4 cycles with count=0, then done.
- **Abort:** abort=1 mid-SHIFT and mid-COUNT (count=3) → all outputs 0 next cycle. No match is possible until 4 fresh pattern bits arrive.
- **Async reset:** reset=0 asserted between edges during COUNT → counting=0 and count=0 immediately, before the next edge. After release, 1,1,0,1 restarts normally.
- **Parameter sweep:** PATTERN=3'b001, PAT_LEN=3, DELAY_W=2, CYCLES_PER_UNIT=1, data 0,0,1,1,1 → delay=3, counting 4 cycles with count 3,2,1,0; ack while not in DONE has no effect.
